// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (logic, add/sub, shifts, compares) produce their result one
// cycle after accept. When SEQ_ALU_MULDIV_EN is defined, opcodes 1100-1111
// (MUL, MULHU, DIVU, REMU) run on a radix-2 iterative datapath for exactly
// XLEN cycles before the result is presented. Without the macro those opcodes
// complete in one cycle with result 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operation presented on op/a/b
//   in_ready   block can accept an operation this cycle
//   op[3:0]    opcode
//   a, b       XLEN-bit operands (shift amount is b[SHW-1:0])
//   out_valid  result/zero valid, held until out_ready
//   out_ready  consumer accepts the result
//   result     XLEN-bit result
//   zero       result == 0, registered alongside result
//   busy       multi-cycle operation in progress
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  state_t          start_state;
  logic            accept;
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] alu_res;

  assign accept = in_valid && in_ready;
  assign sh     = b[SHW-1:0];

  // Single-cycle datapath, evaluated directly on the presented operands.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    alu_res = '0;
    case (op)
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0010: alu_res = a + b;
      4'b0011: alu_res = a ^ b;
      4'b0100: alu_res = a >> sh;
      4'b0110: alu_res = a - b;
      4'b1000: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      4'b1001: alu_res = a << sh;
      4'b1010: alu_res = $signed(a) >>> sh;
      4'b1011: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // Iterative mul/div datapath. hi/lo form a 2*XLEN shift pair:
  //   multiply: hi = partial product, lo = multiplier shifting out the bottom
  //             while product bits shift in at the top.
  //   divide:   hi = partial remainder, lo = dividend shifting out the top
  //             while quotient bits shift in at the bottom.
  logic [XLEN-1:0] hi, lo, dvs;
  logic [1:0]      mop;
  logic [SHW-1:0]  cnt;
  logic            is_multi;
  logic            last_iter;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] hi_nxt, lo_nxt, fin;

  assign is_multi    = (op[3:2] == 2'b11);
  assign start_state = is_multi ? CALC : DONE;
  assign last_iter   = (cnt == SHW'(XLEN - 1));

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    shifted = {hi, lo[XLEN-1]};
    // Divide by zero always "fits": quotient all ones, remainder = dividend.
    ge      = (shifted >= {1'b0, dvs});
    hi_nxt  = '0;
    lo_nxt  = '0;
    if (mop[1]) begin
      // Remainder is always < divisor after the subtract, so XLEN bits hold it.
      hi_nxt = ge ? (shifted[XLEN-1:0] - dvs) : shifted[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], ge};
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end
    // MULHU/REMU take the upper half, MUL/DIVU the lower half.
    fin = mop[0] ? hi_nxt : lo_nxt;
  end

  // NOTE: the iteration registers carry no reset; they are always loaded on
  // accept before being used, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept && is_multi) begin
      hi  <= '0;
      lo  <= a;
      dvs <= b;
      mop <= op[1:0];
      cnt <= '0;
    end else if (state == CALC) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + SHW'(1);
    end
  end

  assign busy = (state == CALC);
`else
  assign start_state = DONE;
  assign busy        = 1'b0;
`endif

  // Next-state and in_ready decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = start_state;
      end
`ifdef SEQ_ALU_MULDIV_EN
      CALC: begin
        if (last_iter) state_nxt = DONE;
      end
`endif
      DONE: begin
        // Consuming the result frees the block for a back-to-back accept.
        if (out_ready) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? start_state : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) in_ready = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && (start_state == DONE)) begin
        result <= alu_res;
        zero   <= (alu_res == '0);
      end
`ifdef SEQ_ALU_MULDIV_EN
      else if ((state == CALC) && last_iter) begin
        result <= fin;
        zero   <= (fin == '0);
      end
`endif
    end
  end

  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- scoreboard bench for seq_alu (XLEN = 32).
// The driver issues operations and records the expected response; a monitor
// on the falling edge pushes it on accept and compares handshakes, busy,
// latency and result against the queue head. Expected results come from
// plain SV arithmetic in ref_op or from literal spec vectors.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int XLEN = 32;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      op = '0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] res;
    int              acc;
    int              lat;
  } txn_t;

  txn_t            q[$];
  int              cycle = 0;
  int              n_cmp = 0;
  int              n_fail = 0;
  int              ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  logic [XLEN-1:0] cur_exp = '0;
  int              cur_lat = 1;
  bit              was_rst = 1'b1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cycle);
  endtask

  function automatic logic [XLEN-1:0] ref_op(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    logic [2*XLEN-1:0] p;
    int s;
    s = int'(y % XLEN);
    p = {{XLEN{1'b0}}, x} * {{XLEN{1'b0}}, y};
    case (o)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return x ^ y;
      4'd4:  return x >> s;
      4'd6:  return x - y;
      4'd8:  return (x < y) ? 1 : 0;
      4'd9:  return x << s;
      4'd10: return $signed(x) >>> s;
      4'd11: return ($signed(x) < $signed(y)) ? 1 : 0;
      4'd12: return MD ? p[XLEN-1:0] : '0;
      4'd13: return MD ? p[2*XLEN-1:XLEN] : '0;
      4'd14: return !MD ? '0 : (y == 0) ? '1 : x / y;
      4'd15: return !MD ? '0 : (y == 0) ? x : x % y;
      default: return '0;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] o);
    return (MD && (o[3:2] == 2'b11)) ? XLEN + 1 : 1;
  endfunction

  // out_ready driver, offset from the stimulus so ready_mode changes settle.
  always begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor / scoreboard.
  bit exp_valid, exp_busy, exp_ready;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("in_ready_in_reset", in_ready, 0);
      q.delete();
      was_rst = 1'b1;
    end else begin
      if (was_rst) begin
        check("reset_result", result, 0);
        check("reset_zero", zero, 0);
        was_rst = 1'b0;
      end
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
      if (q.size() > 0) begin
        exp_valid = (cycle - q[0].acc) >= q[0].lat;
        exp_busy  = (q[0].lat > 1) && !exp_valid;
      end
      exp_ready = (q.size() == 0) || (exp_valid && out_ready);
      check("out_valid", out_valid, exp_valid);
      check("busy", busy, exp_busy);
      check("in_ready", in_ready, exp_ready);
      if (exp_valid && out_valid) begin
        check("result", result, q[0].res);
        check("zero", zero, q[0].res == 0);
      end
      if (exp_valid && out_ready) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back('{res: cur_exp, acc: cycle, lat: cur_lat});
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       input logic [XLEN-1:0] exp);
    int t = 0;
    op = o; a = x; b = y;
    cur_exp = exp;
    cur_lat = lat_of(o);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) timeout("accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic issue_rand(input logic [3:0] o);
    logic [XLEN-1:0] x, y;
    x = $urandom;
    y = $urandom;
    case ($urandom_range(0, 7))
      0: x = '0;
      1: y = '0;
      2: x = '1;
      3: x = 32'h8000_0000;
      4: y = 32'($urandom_range(0, 40));
      default: ;
    endcase
    issue(o, x, y, ref_op(o, x, y));
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c0;
    logic [3:0] singles[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};

    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Spec vectors.
    issue(4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0);
    issue(4'b1011, 32'hFFFF_FFFE, 32'h1, 32'h1);
    issue(4'b1000, 32'hFFFF_FFFE, 32'h1, 32'h0);
    issue(4'b1010, 32'h8000_0000, 32'h24, 32'hF800_0000);
    issue(4'b1100, 32'h1_0000, 32'h1_0000, 32'h0);
    issue(4'b1101, 32'h1_0000, 32'h1_0000, MD ? 32'h1 : 32'h0);
    issue(4'b1110, 32'd100, 32'd7, MD ? 32'd14 : 32'd0);
    issue(4'b1111, 32'd100, 32'd7, MD ? 32'd2 : 32'd0);
    issue(4'b1110, 32'd5, 32'd0, MD ? 32'hFFFF_FFFF : 32'd0);
    issue(4'b1111, 32'd5, 32'd0, MD ? 32'd5 : 32'd0);
    issue(4'b0101, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
    wait_drain();

    // Output stall, then back-to-back accept on release.
    ready_mode = 2;
    issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    idle(5);
    ready_mode = 0;
    c0 = cycle;
    issue(4'b0011, 32'hAAAA_0000, 32'h5555_FFFF, 32'hFFFF_FFFF);
    check("b2b_accept_cycles", cycle - c0, 1);
    wait_drain();

    // Full throughput with out_ready held high.
    c0 = cycle;
    for (int i = 0; i < 8; i++) issue_rand(singles[$urandom_range(0, 9)]);
    check("throughput_cycles", cycle - c0, 8);
    wait_drain();

    // Reset during CALC cycle 10 of a DIVU.
    issue(4'b1110, 32'd1000, 32'd3, MD ? 32'd333 : 32'd0);
    idle(9);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(45);

    // Randomized traffic with random backpressure and gaps.
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      issue_rand(4'($urandom));
      idle($urandom_range(0, 2));
    end
    ready_mode = 0;
    wait_drain();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "watchdog");
  end

endmodule
